// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 8 data bits LSB first,
// odd parity, stop, then device ACK check. Outputs drive open-collector pads (oe=1 pulls low).
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int RTS_CYCLES     = 50,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int FILTER_LEN     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_byte,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int PW = $clog2((INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int FW = $clog2(FILTER_LEN) + 1;

    localparam logic [PW-1:0] INH_LAST = PW'(INHIBIT_CYCLES - 1);
    localparam logic [PW-1:0] RTS_LAST = PW'(RTS_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_RTS, S_SHIFT, S_ACK, S_WAIT_IDLE, S_DONE, S_ERROR
    } state_t;

    state_t        state_q, state_d;
    logic          clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
    logic          dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
    logic          filt_q, filt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    byte_q, byte_d;
    logic          par_q, par_d;
    logic          clk_oe_q, clk_oe_d;
    logic          dat_oe_q, dat_oe_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          fall;

    always_comb begin
        clk_s1_d = ps2_clk_in;
        clk_s2_d = clk_s1_q;
        dat_s1_d = ps2_dat_in;
        dat_s2_d = dat_s1_q;

        // Filtered clock only moves after FILTER_LEN consecutive samples disagree with it
        filt_d = filt_q;
        fcnt_d = '0;
        if (clk_s2_q != filt_q) begin
            if (fcnt_q == FLT_LAST) begin
                filt_d = clk_s2_q;
            end else begin
                fcnt_d = fcnt_q + FW'(1);
            end
        end
        fall = filt_q & ~filt_d;

        state_d  = state_q;
        pcnt_d   = pcnt_q;
        tcnt_d   = tcnt_q;
        bitcnt_d = bitcnt_q;
        byte_d   = byte_q;
        par_d    = par_q;
        clk_oe_d = clk_oe_q;
        dat_oe_d = dat_oe_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (tx_start) begin
                    byte_d   = tx_byte;
                    par_d    = ~^tx_byte;
                    pcnt_d   = '0;
                    clk_oe_d = 1'b1;
                    dat_oe_d = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (pcnt_q == INH_LAST) begin
                    pcnt_d   = '0;
                    dat_oe_d = 1'b1;
                    state_d  = S_RTS;
                end else begin
                    pcnt_d = pcnt_q + PW'(1);
                end
            end
            S_RTS: begin
                if (pcnt_q == RTS_LAST) begin
                    clk_oe_d = 1'b0;
                    bitcnt_d = '0;
                    tcnt_d   = '0;
                    state_d  = S_SHIFT;
                end else begin
                    pcnt_d = pcnt_q + PW'(1);
                end
            end
            S_SHIFT, S_ACK, S_WAIT_IDLE: begin
                tcnt_d = tcnt_q + TW'(1);
                if (tcnt_q == TO_LAST) begin
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b0;
                    err_d    = 1'b1;
                    state_d  = S_ERROR;
                end else if (state_q == S_SHIFT) begin
                    // Next bit goes out on each device falling edge; the 10th fall presents stop
                    if (fall) begin
                        bitcnt_d = bitcnt_q + 4'd1;
                        if (bitcnt_q < 4'd8) begin
                            dat_oe_d = ~byte_q[bitcnt_q[2:0]];
                        end else if (bitcnt_q == 4'd8) begin
                            dat_oe_d = ~par_q;
                        end else begin
                            dat_oe_d = 1'b0;
                            state_d  = S_ACK;
                        end
                    end
                end else if (state_q == S_ACK) begin
                    if (fall) begin
                        if (dat_s2_q) begin
                            err_d   = 1'b1;
                            state_d = S_ERROR;
                        end else begin
                            state_d = S_WAIT_IDLE;
                        end
                    end
                end else begin
                    if (filt_q && dat_s2_q) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE, S_ERROR: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d   = 1'b0;
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                state_d  = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
            filt_q   <= 1'b1;
            fcnt_q   <= '0;
            pcnt_q   <= '0;
            tcnt_q   <= '0;
            bitcnt_q <= '0;
            byte_q   <= '0;
            par_q    <= 1'b0;
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            clk_s1_q <= clk_s1_d;
            clk_s2_q <= clk_s2_d;
            dat_s1_q <= dat_s1_d;
            dat_s2_q <= dat_s2_d;
            filt_q   <= filt_d;
            fcnt_q   <= fcnt_d;
            pcnt_q   <= pcnt_d;
            tcnt_q   <= tcnt_d;
            bitcnt_q <= bitcnt_d;
            byte_q   <= byte_d;
            par_q    <= par_d;
            clk_oe_q <= clk_oe_d;
            dat_oe_q <= dat_oe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign ps2_clk_oe = clk_oe_q;
    assign ps2_dat_oe = dat_oe_q;
    assign busy       = busy_q;
    assign tx_done    = done_q;
    assign tx_error   = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of the host and
// checks each bit against a scoreboard of expected frame bits.
module tb_ps2_host_tx;

    localparam int INH = 20;
    localparam int RTS = 4;
    localparam int TO  = 2000;
    localparam int FL  = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       tx_start;
    logic [7:0] tx_byte;
    logic       ps2_clk_in, ps2_dat_in;
    logic       ps2_clk_oe, ps2_dat_oe;
    logic       busy, tx_done, tx_error;
    logic       dev_clk, dev_dat;

    int vectors     = 0;
    int miscompares = 0;
    int done_cnt    = 0;
    int err_cnt     = 0;
    bit exp_q[$];

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       ack;
        logic       glitch;
        logic       poke;
        int         exp_done;
        int         exp_err;
    } vec_t;

    vec_t tbl[5];
    vec_t v_f4;

    always #5 clk = ~clk;

    // Open-collector wired-AND of host and device
    assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
    assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .RTS_CYCLES    (RTS),
        .TIMEOUT_CYCLES(TO),
        .FILTER_LEN    (FL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tx_start  (tx_start),
        .tx_byte   (tx_byte),
        .ps2_clk_in(ps2_clk_in),
        .ps2_dat_in(ps2_dat_in),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_dat_oe(ps2_dat_oe),
        .busy      (busy),
        .tx_done   (tx_done),
        .tx_error  (tx_error)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bit prev_pulse;
        prev_pulse = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_pulse) check("busy_after_pulse", 32'(busy), 32'd0);
            if (tx_done || tx_error) begin
                check("done_err_exclusive", 32'(tx_done & tx_error), 32'd0);
                check("busy_during_pulse", 32'(busy), 32'd1);
            end
            if (tx_done) done_cnt++;
            if (tx_error) err_cnt++;
            prev_pulse = tx_done | tx_error;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    task automatic start_tx(input logic [7:0] b);
        tx_byte  = b;
        tx_start = 1'b1;
        tick(1);
        tx_start = 1'b0;
        check("busy_accept", 32'(busy), 32'd1);
    endtask

    task automatic preamble();
        int n;
        n = 0;
        while (ps2_clk_oe && !ps2_dat_oe && n < 100) begin
            n++;
            tick(1);
        end
        check("inhibit_len", 32'(n), 32'(INH));
        n = 0;
        while (ps2_clk_oe && ps2_dat_oe && n < 100) begin
            n++;
            tick(1);
        end
        check("rts_len", 32'(n), 32'(RTS));
        check("shift_lines", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'b01);
    endtask

    // One device clock period: 20 low, rising edge samples data, 20 high
    task automatic dev_clock(input int idx, input bit glitch, input bit poke,
                             input bit last, input bit ack);
        bit b;
        dev_clk = 1'b0;
        if (glitch) begin
            tick(10); dev_clk = 1'b1; tick(1); dev_clk = 1'b0; tick(9);
        end else begin
            tick(20);
        end
        dev_clk = 1'b1;
        if (exp_q.size() == 0) begin
            check($sformatf("scoreboard_empty_bit%0d", idx), 32'd1, 32'd0);
        end else begin
            b = exp_q.pop_front();
            check($sformatf("bit%0d", idx), 32'(ps2_dat_in), 32'(b));
        end
        if (last) begin
            tick(10); dev_dat = ~ack; tick(10);
        end else if (glitch) begin
            tick(10); dev_clk = 1'b0; tick(1); dev_clk = 1'b1; tick(9);
        end else if (poke) begin
            tick(5);
            tx_byte  = 8'h55;
            tx_start = 1'b1;
            tick(1);
            tx_start = 1'b0;
            tick(14);
        end else begin
            tick(20);
        end
    endtask

    task automatic run_vector(input vec_t v);
        int d0, e0, k;
        for (int i = 0; i < 8; i++) exp_q.push_back(v.data[i]);
        exp_q.push_back(v.par);
        exp_q.push_back(1'b1);
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(v.data);
        preamble();
        tick(10);
        check("start_bit", 32'(ps2_dat_in), 32'd0);
        for (int i = 1; i <= 10; i++)
            dev_clock(i, v.glitch && (i == 4 || i == 7), v.poke && i == 3, i == 10, v.ack);
        dev_clk = 1'b0;
        tick(20);
        dev_clk = 1'b1;
        dev_dat = 1'b1;
        k = 0;
        while (busy && k < 60) begin
            k++;
            tick(1);
        end
        check("end_of_frame_bound", 32'(k < 60), 32'd1);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check("done_pulses", 32'(done_cnt - d0), 32'(v.exp_done));
        check("error_pulses", 32'(err_cnt - e0), 32'(v.exp_err));
        check("lines_released", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
    endtask

    initial begin
        int d0, e0, k;
        reset    = 1'b1;
        tx_start = 1'b0;
        tx_byte  = 8'h00;
        dev_clk  = 1'b1;
        dev_dat  = 1'b1;
        tick(3);
        check("reset_outputs", {27'd0, ps2_clk_oe, ps2_dat_oe, busy, tx_done, tx_error}, 32'd0);
        reset = 1'b0;
        tick(5);

        //            data   par   ack   glitch poke  done err
        tbl[0] = '{8'hED, 1'b1, 1'b1, 1'b0, 1'b0, 1, 0};
        tbl[1] = '{8'h02, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0};
        tbl[2] = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1, 0};
        tbl[3] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1};
        tbl[4] = '{8'hED, 1'b1, 1'b1, 1'b0, 1'b1, 1, 0};
        v_f4   = '{8'hF4, 1'b0, 1'b1, 1'b1, 1'b0, 1, 0};

        for (int i = 0; i < 5; i++) run_vector(tbl[i]);

        // Device never clocks: timeout exactly TO cycles after the first SHIFT cycle
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(8'hED);
        preamble();
        k = 0;
        while (!tx_error && k < 3000) begin
            k++;
            tick(1);
        end
        check("timeout_cycles", 32'(k), 32'(TO));
        check("timeout_lines", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
        tick(2);
        check("timeout_done_pulses", 32'(done_cnt - d0), 32'd0);
        check("timeout_error_pulses", 32'(err_cnt - e0), 32'd1);

        // Reset mid-frame after the 5th falling edge (0xED bit4=0 keeps data pulled low)
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
        start_tx(8'hED);
        preamble();
        tick(10);
        for (int i = 1; i <= 5; i++) dev_clock(i, 1'b0, 1'b0, 1'b0, 1'b0);
        check("abort_pre_dat_oe", 32'(ps2_dat_oe), 32'd1);
        d0 = done_cnt;
        e0 = err_cnt;
        #2 reset = 1'b1;
        #1 check("abort_lines", {29'd0, ps2_clk_oe, ps2_dat_oe, busy}, 32'd0);
        tick(2);
        reset = 1'b0;
        tick(5);
        check("abort_no_pulse", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
        check("abort_idle", 32'(busy), 32'd0);

        run_vector(v_f4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
